// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT: issues operand reads,
// tags each pair with its upper address and turns the returning tag into write-back addresses.
`timescale 1ns/1ps
module fft_stage_ctrl #(
    parameter int LOG2N      = 3,
    parameter int RD_LATENCY = 1,
    parameter int BF_LATENCY = 4,
    parameter int TAG_WIDTH  = LOG2N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [LOG2N-1:0]     rd_addr_a,
    output logic [LOG2N-1:0]     rd_addr_b,
    output logic [LOG2N-2:0]     tw_addr,
    output logic [TAG_WIDTH-1:0] bf_tag,
    input  logic [TAG_WIDTH-1:0] bf_tag_ret,
    output logic                 wr_en,
    output logic [LOG2N-1:0]     wr_addr_a,
    output logic [LOG2N-1:0]     wr_addr_b
);
    localparam int SW  = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int KW  = LOG2N - 1;
    localparam int PL  = RD_LATENCY + BF_LATENCY;
    localparam int DW  = $clog2(PL) + 1;
    localparam logic [KW-1:0] KMAX = {KW{1'b1}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_s, w_s_nxt;
    logic [KW-1:0]   r_k, w_k_nxt;
    logic [DW-1:0]   r_drain, w_drain_nxt;
    logic [LOG2N-1:0] r_rd_a, r_rd_b, r_wr_a, r_wr_b;
    logic [LOG2N-2:0] r_tw;
    logic [LOG2N-1:0] r_tag [RD_LATENCY];
    logic            r_vld [PL];
    logic            w_rd_en;
    logic [LOG2N-1:0] w_ret, w_half;

    function automatic logic [LOG2N-1:0] f_addr_a(input logic [SW-1:0] s, input logic [KW-1:0] k);
        logic [LOG2N-1:0] kk, mask, pos, grp;
        kk   = {1'b0, k};
        mask = (LOG2N'(1) << s) - LOG2N'(1);
        pos  = kk & mask;
        grp  = kk >> s;
        return (grp << (int'(s) + 1)) | pos;
    endfunction

    function automatic logic [LOG2N-2:0] f_tw(input logic [SW-1:0] s, input logic [KW-1:0] k);
        logic [LOG2N-1:0] kk, mask, w;
        kk   = {1'b0, k};
        mask = (LOG2N'(1) << s) - LOG2N'(1);
        w    = (kk & mask) << (LOG2N - 1 - int'(s));
        return w[LOG2N-2:0];
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_k_nxt     = r_k;
        w_drain_nxt = r_drain;
        case (r_state)
            IDLE: if (start) begin
                w_state_nxt = ISSUE;
                w_s_nxt     = '0;
                w_k_nxt     = '0;
            end
            ISSUE: if (r_k == KMAX) begin
                w_state_nxt = DRAIN;
                w_k_nxt     = '0;
                w_drain_nxt = '0;
            end else begin
                w_k_nxt = r_k + KW'(1);
            end
            // Stage may only advance once every in-flight pair has been written back.
            DRAIN: if (r_drain == DW'(PL - 1)) begin
                w_drain_nxt = '0;
                if (r_s == SW'(LOG2N - 1)) begin
                    w_state_nxt = FINISH;
                end else begin
                    w_s_nxt     = r_s + SW'(1);
                    w_state_nxt = ISSUE;
                end
            end else begin
                w_drain_nxt = r_drain + DW'(1);
            end
            FINISH: begin
                w_state_nxt = IDLE;
                w_s_nxt     = '0;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_rd_en = (r_state == ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_k     <= '0;
            r_drain <= '0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= '0;
            r_wr_a  <= '0;
            r_wr_b  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) r_tag[i] <= '0;
            for (int i = 0; i < PL; i++) r_vld[i] <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_k     <= w_k_nxt;
            r_drain <= w_drain_nxt;
            // Addresses are prepared one edge ahead so they line up with the ISSUE cycle.
            if (w_state_nxt == ISSUE) begin
                r_rd_a <= f_addr_a(w_s_nxt, w_k_nxt);
                r_rd_b <= f_addr_a(w_s_nxt, w_k_nxt) + (LOG2N'(1) << w_s_nxt);
                r_tw   <= f_tw(w_s_nxt, w_k_nxt);
            end
            if (wr_en) begin
                r_wr_a <= w_ret;
                r_wr_b <= w_ret + w_half;
            end
            r_tag[0] <= r_rd_a;
            for (int i = 1; i < RD_LATENCY; i++) r_tag[i] <= r_tag[i-1];
            r_vld[0] <= w_rd_en;
            for (int i = 1; i < PL; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    assign w_ret     = LOG2N'(bf_tag_ret);
    assign w_half    = LOG2N'(1) << r_s;
    assign busy      = (r_state == ISSUE) || (r_state == DRAIN);
    assign done      = (r_state == FINISH);
    assign rd_en     = w_rd_en;
    assign rd_addr_a = r_rd_a;
    assign rd_addr_b = r_rd_b;
    assign tw_addr   = r_tw;
    assign bf_tag    = TAG_WIDTH'(r_tag[RD_LATENCY-1]);
    assign wr_en     = r_vld[PL-1];
    assign wr_addr_a = wr_en ? w_ret : r_wr_a;
    assign wr_addr_b = wr_en ? (w_ret + w_half) : r_wr_b;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl at N=8, with a 4-cycle butterfly tag delay model.
`timescale 1ns/1ps
module tb_fft_stage_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, rd_en, wr_en;
    logic [2:0] rd_addr_a, rd_addr_b, bf_tag, bf_tag_ret, wr_addr_a, wr_addr_b;
    logic [1:0] tw_addr;
    logic [2:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
    int         n_err = 0;
    int         n_chk = 0;

    fft_stage_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .bf_tag(bf_tag), .bf_tag_ret(bf_tag_ret),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    always #5 clk = ~clk;

    // Butterfly model: m_out is m_in delayed by four cycles.
    always @(posedge clk) begin
        d1 <= bf_tag;
        d2 <= d1;
        d3 <= d2;
        d4 <= d3;
    end
    assign bf_tag_ret = d4;

    function automatic logic [20:0] obs_vec();
        return {rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_tag, wr_en, wr_addr_a, wr_addr_b, busy, done};
    endfunction

    // Expected outputs t cycles after a start at t=0 (default run); fresh means held values start at 0,
    // otherwise they are the last pair (3,7,3) of a previous run.
    function automatic logic [20:0] exp_vec(input int t, input bit fresh);
        int ra [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        int rb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        int rt [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
        logic re, we, bz, dn;
        int ha, hb, htw, ta, wa, wb, rc;
        re = 1'b0; we = 1'b0;
        ha = fresh ? 0 : 3; hb = fresh ? 0 : 7; htw = fresh ? 0 : 3;
        ta = ha; wa = ha; wb = hb;
        for (int i = 0; i < 12; i++) begin
            rc = 1 + 9 * (i / 4) + (i % 4);
            if (rc == t) re = 1'b1;
            if (rc <= t) begin ha = ra[i]; hb = rb[i]; htw = rt[i]; end
            if (rc <= t - 1) ta = ra[i];
            if (rc + 5 == t) we = 1'b1;
            if (rc + 5 <= t) begin wa = ra[i]; wb = rb[i]; end
        end
        bz = (t >= 1) && (t <= 27);
        dn = (t == 28);
        return {re, 3'(ha), 3'(hb), 2'(htw), 3'(ta), we, 3'(wa), 3'(wb), bz, dn};
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [20:0] o;
        rst = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = obs_vec();
            n_chk++;
            if (o !== 21'd0) begin
                n_err++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", i, o, 21'd0);
            end
        end
        rst = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_default_run();
        logic [20:0] o, e;
        apply_reset();
        for (int t = 0; t <= 31; t++) begin
            @(negedge clk);
            o = obs_vec();
            e = exp_vec(t, 1'b1);
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL default_run t=%0d got=%h exp=%h", t, o, e);
            end
            start = (t == 0);
        end
        start = 1'b0;
    endtask

    task automatic test_duplicate_start();
        logic [20:0] o, e;
        apply_reset();
        for (int t = 0; t <= 31; t++) begin
            @(negedge clk);
            o = obs_vec();
            e = exp_vec(t, 1'b1);
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL dup_start t=%0d got=%h exp=%h", t, o, e);
            end
            start = (t == 0) || (t == 5) || (t == 20);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [20:0] o, e;
        apply_reset();
        for (int t = 0; t <= 45; t++) begin
            @(negedge clk);
            o = obs_vec();
            if (t <= 12)      e = exp_vec(t, 1'b1);
            else if (t < 15)  e = 21'd0;
            else              e = exp_vec(t - 15, 1'b1);
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_mid_run t=%0d got=%h exp=%h", t, o, e);
            end
            start = (t == 0) || (t == 15);
            rst   = (t == 12);
        end
        start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [20:0] o, e;
        apply_reset();
        for (int t = 0; t <= 60; t++) begin
            @(negedge clk);
            o = obs_vec();
            e = (t < 29) ? exp_vec(t, 1'b1) : exp_vec(t - 29, 1'b0);
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL back_to_back t=%0d got=%h exp=%h", t, o, e);
            end
            start = (t == 0) || (t == 29);
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_duplicate_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
